// File: rtl/branch_controller.sv
// -----------------------------------------------------------------------------
// branch_controller
//
// Control-flow decoder that drives the program counter's jump interface.
// It recognises JMP / CALL / RET / JZ in the fetched instruction stream,
// keeps a hardware return-address stack so that CALL/RET can nest, and
// squashes the wrong-path instructions that were already fetched behind a
// taken branch.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   instr_valid  in   instr / instr_pc carry a fetched instruction this cycle
//   instr        in   16-bit instruction word (opcode in [15:12])
//   instr_pc     in   address the instruction was fetched from
//   zero_flag    in   ALU zero flag, qualifies JZ
//   jump_enable  out  one-cycle pulse: PC loads jump_address
//   jump_address out  branch target, held between pulses
//   squash       out  current valid beat is wrong-path and must be discarded
//   stack_depth  out  number of live return-address stack entries
//   fault        out  sticky stack overflow / underflow indication
// -----------------------------------------------------------------------------
module branch_controller #(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    input  logic [15:0]                instr,
    input  logic [15:0]                instr_pc,
    input  logic                       zero_flag,
    output logic                       jump_enable,
    output logic [15:0]                jump_address,
    output logic                       squash,
    output logic [$clog2(DEPTH):0]     stack_depth,
    output logic                       fault
);

    localparam int AW = $clog2(DEPTH);          // stack index width
    localparam int DW = AW + 1;                 // depth counter width (0..DEPTH)
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [DW-1:0] DEPTH_FULL  = DW'(DEPTH);
    localparam logic [CW-1:0] FLUSH_LOAD  = CW'(FLUSH_CYCLES);

    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_flush_cnt;
    logic [CW-1:0]   w_flush_cnt_next;
    logic [DW-1:0]   r_depth;
    logic [DW-1:0]   w_depth_next;
    logic            r_jump_enable;
    logic [15:0]     r_jump_address;
    logic            r_fault;

    logic [15:0]     r_stack [DEPTH];

    // ---------------------------------------------------------------------
    // Decode helpers
    // ---------------------------------------------------------------------
    logic [3:0]      w_opcode;
    logic [15:0]     w_imm_target;
    logic [15:0]     w_return_addr;
    logic [AW-1:0]   w_push_idx;
    logic [AW-1:0]   w_pop_idx;
    logic            w_push;
    logic            w_taken;
    logic [15:0]     w_target;

    assign w_opcode      = instr[15:12];
    assign w_imm_target  = {4'h0, instr[11:0]};
    // 16-bit add wraps, so a CALL at 16'hFFFF returns to 16'h0000.
    assign w_return_addr = instr_pc + 16'd1;
    // Pointer equals the entry count: push lands on entry[depth], pop reads
    // entry[depth-1]. The full/empty guards keep these indices in range.
    assign w_push_idx    = r_depth[AW-1:0];
    assign w_pop_idx     = r_depth[AW-1:0] - AW'(1);

    // ---------------------------------------------------------------------
    // Next-state / decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_depth_next     = r_depth;
        w_push           = 1'b0;
        w_taken          = 1'b0;
        w_target         = w_imm_target;

        case (r_state)
            ST_RUN: begin
                if (instr_valid) begin
                    case (w_opcode)
                        OP_JMP: begin
                            w_taken = 1'b1;
                        end
                        OP_CALL: begin
                            if (r_depth == DEPTH_FULL) begin
                                w_state_next = ST_FAULT;
                            end else begin
                                w_push       = 1'b1;
                                w_depth_next = r_depth + DW'(1);
                                w_taken      = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (r_depth == '0) begin
                                w_state_next = ST_FAULT;
                            end else begin
                                w_depth_next = r_depth - DW'(1);
                                w_target     = r_stack[w_pop_idx];
                                w_taken      = 1'b1;
                            end
                        end
                        OP_JZ: begin
                            w_taken = zero_flag;
                        end
                        default: begin
                        end
                    endcase

                    if (w_taken) begin
                        w_state_next     = ST_FLUSH;
                        w_flush_cnt_next = FLUSH_LOAD;
                    end
                end
            end

            ST_FLUSH: begin
                // Only real fetch beats consume the flush budget; bubbles
                // carry no wrong-path instruction.
                if (instr_valid) begin
                    if (r_flush_cnt <= CW'(1)) begin
                        w_flush_cnt_next = '0;
                        w_state_next     = ST_RUN;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt - CW'(1);
                    end
                end
            end

            ST_FAULT: begin
                // Terminal until reset: everything is ignored.
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_RUN;
            r_flush_cnt    <= '0;
            r_depth        <= '0;
            r_jump_enable  <= 1'b0;
            r_jump_address <= 16'h0000;
            r_fault        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_flush_cnt   <= w_flush_cnt_next;
            r_depth       <= w_depth_next;
            r_jump_enable <= w_taken;
            if (w_taken) begin
                r_jump_address <= w_target;
            end
            if (w_state_next == ST_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Stack storage has no reset: contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_return_addr;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign jump_enable  = r_jump_enable;
    assign jump_address = r_jump_address;
    assign stack_depth  = r_depth;
    assign fault        = r_fault;
    // Squash follows the live valid beat so the consumer can drop it in the
    // same cycle it is presented.
    assign squash       = (r_state == ST_FLUSH) && instr_valid;

endmodule
